// File: rtl/burst_address_gen.sv
// Streams one address per beat for a (base, len, mode) command; wrapping bursts built only with BURST_ADDR_WRAP_EN.
// Latency: first address 1 cycle after the command handshake; 1 beat/cycle; 1 idle cycle between bursts.
// Backpressure: addr_valid holds with stable address/index/last until addr_ready; start_ready only while idle.
`default_nettype none

module burst_address_gen #(
   parameter int ADDR_W  = 32,
   parameter int STRIDE  = 4,
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_valid,
   output logic                start_ready,
   input  logic [ADDR_W-1:0]   start_addr,
   input  logic [LEN_W-1:0]    start_len,
   input  logic                start_wrap,
   output logic                addr_valid,
   input  logic                addr_ready,
   output logic [ADDR_W-1:0]   addr_out,
   output logic [LEN_W-2:0]    addr_index,
   output logic                addr_last,
   output logic                busy
);

   localparam int                IDX_W     = LEN_W - 1;
   localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(STRIDE);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] addr_nxt;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  last_idx_q;
   logic [LEN_W-1:0]  eff_len;
   logic [LEN_W-1:0]  eff_len_m1;
   logic              at_last;
   logic              cmd_fire;
   logic              beat_fire;

   // Oversized requests are clamped; a zero length is consumed without starting a burst.
   assign eff_len    = (start_len > MAX_LEN_L) ? MAX_LEN_L : start_len;
   assign eff_len_m1 = eff_len - LEN_W'(1);
   assign addr_inc   = addr_q + STRIDE_A;
   assign at_last    = (idx_q == last_idx_q);
   assign cmd_fire   = (state_q == IDLE) && start_valid && (eff_len != '0);
   assign beat_fire  = (state_q == BURST) && addr_ready;

`ifdef BURST_ADDR_WRAP_EN
   logic              wrap_q;
   logic [ADDR_W-1:0] mask_q;
   logic              len_pow2;
   logic [ADDR_W-1:0] blk_mask;

   assign len_pow2 = ((eff_len & eff_len_m1) == '0);
   assign blk_mask = (ADDR_W'(eff_len) * STRIDE_A) - ADDR_W'(1);

   // Wrap keeps the block-aligned upper bits and lets only the in-block offset roll over.
   assign addr_nxt = wrap_q ? ((addr_q & ~mask_q) | (addr_inc & mask_q)) : addr_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap_q <= 1'b0;
         mask_q <= '0;
      end else if (cmd_fire) begin
         wrap_q <= start_wrap && len_pow2;
         mask_q <= blk_mask;
      end
   end
`else
   logic unused_bits;

   assign addr_nxt    = addr_inc;
   assign unused_bits = ^{start_wrap, eff_len_m1[LEN_W-1]};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      start_ready = 1'b0;
      addr_valid  = 1'b0;
      busy        = 1'b0;
      addr_last   = 1'b0;
      case (state_q)
         IDLE: begin
            start_ready = 1'b1;
            if (cmd_fire) begin
               state_d = BURST;
            end
         end
         BURST: begin
            addr_valid = 1'b1;
            busy       = 1'b1;
            addr_last  = at_last;
            if (beat_fire && at_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         idx_q      <= '0;
         last_idx_q <= '0;
      end else if (cmd_fire) begin
         addr_q     <= start_addr;
         idx_q      <= '0;
         last_idx_q <= eff_len_m1[IDX_W-1:0];
      end else if (beat_fire && !at_last) begin
         addr_q <= addr_nxt;
         idx_q  <= idx_q + IDX_W'(1);
      end
   end

   assign addr_out   = addr_q;
   assign addr_index = idx_q;

endmodule

`default_nettype wire
